// File: rtl/wbu.sv
// Write-back unit: commits GPR/CSR writes, counts retired instructions and
// hands the next PC to the IFU through a valid/ready handshake.
module wbu #(
    parameter logic [31:0] INSTRET_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbu_receive_valid,
    input  logic [31:0] wd,
    input  logic [31:0] csr_wd,
    input  logic [4:0]  rd,
    input  logic [1:0]  csr_rd,
    input  logic        reg_en,
    input  logic        csreg_en,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic [31:0] pc,
    input  logic [31:0] pc_next,
    input  logic [31:0] instruction,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [1:0]  csr_rs,
    input  logic        ifu_ready,
    output logic        wbu_receive_ready,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] csr_rdata,
    output logic        wbu_send_valid,
    output logic [31:0] dnpc,
    output logic [4:0]  rd_wbu_to_idu,
    output logic [1:0]  csr_rd_wbu_to_idu,
    output logic        wbu_state,
    output logic        halt,
    output logic [31:0] instret
);

    // state  | meaning
    // IDLE   | waiting for an LSU result; the only state that accepts
    // COMMIT | one cycle: register/CSR writes and instret update
    // SEND   | dnpc offered to the IFU until ifu_ready
    // HALT   | ebreak retired; frozen until reset
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        SEND   = 2'd2,
        HALT   = 2'd3
    } state_t;

    localparam logic [1:0]  CSR_MCAUSE    = 2'd3;
    localparam logic [31:0] MCAUSE_ECALL  = 32'd11;
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    state_t      state;
    logic [31:0] rf  [0:31];
    logic [31:0] csr [0:3];

    logic [31:0] lat_wd;
    logic [31:0] lat_csr_wd;
    logic [31:0] lat_pc_next;
    logic [4:0]  lat_rd;
    logic [1:0]  lat_csr_rd;
    logic        lat_reg_en;
    logic        lat_csreg_en;
    logic        lat_ecall;
    logic        lat_ebreak;

    // pc and instruction are carried for trace/debug consumers only.
    logic unused_trace;
    assign unused_trace = ^{pc, instruction};

    assign wbu_receive_ready = (state == IDLE);
    assign wbu_state         = (state != IDLE);
    assign rd_wbu_to_idu     = (state == IDLE) ? rd     : lat_rd;
    assign csr_rd_wbu_to_idu = (state == IDLE) ? csr_rd : lat_csr_rd;

    assign rs1_data  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_data  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    assign csr_rdata = csr[csr_rs];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
            csr[0]         <= MSTATUS_RESET;
            csr[1]         <= 32'd0;
            csr[2]         <= 32'd0;
            csr[3]         <= 32'd0;
            lat_wd         <= 32'd0;
            lat_csr_wd     <= 32'd0;
            lat_pc_next    <= 32'd0;
            lat_rd         <= 5'd0;
            lat_csr_rd     <= 2'd0;
            lat_reg_en     <= 1'b0;
            lat_csreg_en   <= 1'b0;
            lat_ecall      <= 1'b0;
            lat_ebreak     <= 1'b0;
            wbu_send_valid <= 1'b0;
            dnpc           <= 32'd0;
            halt           <= 1'b0;
            instret        <= INSTRET_RESET;
        end else begin
            case (state)
                IDLE: begin
                    if (wbu_receive_valid) begin
                        lat_wd       <= wd;
                        lat_csr_wd   <= csr_wd;
                        lat_pc_next  <= pc_next;
                        lat_rd       <= rd;
                        lat_csr_rd   <= csr_rd;
                        lat_reg_en   <= reg_en;
                        lat_csreg_en <= csreg_en;
                        lat_ecall    <= ecall;
                        lat_ebreak   <= ebreak;
                        state        <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (lat_reg_en && (lat_rd != 5'd0)) begin
                        rf[lat_rd] <= lat_wd;
                    end
                    if (lat_csreg_en) begin
                        csr[lat_csr_rd] <= lat_csr_wd;
                    end
                    // Placed after the generic CSR write so ecall overrides it.
                    if (lat_ecall) begin
                        csr[CSR_MCAUSE] <= MCAUSE_ECALL;
                    end
                    instret <= instret + 32'd1;
                    if (lat_ebreak) begin
                        halt  <= 1'b1;
                        state <= HALT;
                    end else begin
                        wbu_send_valid <= 1'b1;
                        dnpc           <= lat_pc_next;
                        state          <= SEND;
                    end
                end
                SEND: begin
                    if (ifu_ready) begin
                        wbu_send_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                HALT: begin
                    halt <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-003 wbu_receive_valid  input  1  LSU result valid (driven by lsu_send_valid).
REQ-004 wd, csr_wd  input  32 each  GPR and CSR write data.
REQ-005 rd  input  5; csr_rd  input  2  destination GPR and destination CSR (0 mstatus, 1 mtvec, 2 mepc, 3 mcause).
REQ-006 reg_en, csreg_en, ecall, ebreak  input  1 each  commit controls.
REQ-007 pc, pc_next, instruction  input  32 each  committing instruction information.
REQ-008 rs1, rs2  input  5; csr_rs  input  2  IDU read addresses.
REQ-009 ifu_ready  input  1  IFU accepts next-PC.
REQ-010 wbu_receive_ready  output  1  WBU can accept; high iff state==IDLE.
REQ-011 rs1_data, rs2_data, csr_rdata  output  32 each  combinational register-file and CSR reads.
REQ-012 wbu_send_valid  output  1; dnpc  output  32  next PC to IFU.
REQ-013 rd_wbu_to_idu  output  5; csr_rd_wbu_to_idu  output  2  hazard tags; equal the inputs in IDLE, the latched values otherwise.
REQ-014 wbu_state  output  1  high when state!=IDLE.
REQ-015 halt  output  1; instret  output  32  ebreak seen; retired-instruction count.

Function
REQ-016 The FSM SHALL have states IDLE, COMMIT, SEND and HALT, and SHALL reset to IDLE.
REQ-017 IDLE: on wbu_receive_valid=1, latch all data and control inputs and move to COMMIT; otherwise stay in IDLE.
REQ-018 COMMIT lasts exactly 1 cycle.
- GPR write: rf[rd] <= wd when reg_en=1 and rd!=0.
- CSR write: csr[csr_rd] <= csr_wd when csreg_en=1.
- instret increments by 1 and wraps 0xFFFFFFFF -> 0.
REQ-019 An ecall in COMMIT SHALL also write mcause <= 11; if csreg_en targets mcause in the same cycle, ecall wins.
REQ-020 An ebreak in COMMIT SHALL perform all writes of REQ-018, set halt=1 and go to HALT.
REQ-021 Otherwise COMMIT SHALL go to SEND, with wbu_send_valid=1 and dnpc=latched pc_next registered on entry to SEND.
REQ-022 SEND: wbu_send_valid and dnpc SHALL hold stable until ifu_ready=1; on that cycle go to IDLE with wbu_send_valid=0 next cycle.
REQ-023 HALT SHALL be terminal until reset: no acceptance, no send, and halt held at 1.
REQ-024 rf[0] SHALL always read 0.
REQ-025 Reads SHALL return stored values with no bypass; a read during COMMIT returns the pre-write value.
REQ-026 wbu_receive_valid in any non-IDLE state SHALL be ignored; LSU holds valid only while wbu_receive_ready=1.
REQ-027 Minimum throughput SHALL be 1 instruction per 3 cycles (IDLE, COMMIT, SEND with ifu_ready=1).

Reset
REQ-028 rst=0 SHALL give:
- state=IDLE; all rf=0; mstatus=32'h00001800; mtvec, mepc, mcause=0.
- wbu_send_valid=0, dnpc=0, halt=0, instret=0.
REQ-029 Reset asserted mid-COMMIT or mid-SEND SHALL abort immediately; the write in flight is discarded if reset precedes the edge.

Verification
REQ-030 valid, reg_en=1, rd=5, wd=0xDEADBEEF, pc_next=0x80000004, ifu_ready=1 -> rs1=5 reads 0xDEADBEEF after COMMIT; wbu_send_valid=1 for one cycle with dnpc=0x80000004; instret=1.
REQ-031 reg_en=1, rd=0, wd=0x1234 -> rs1=0 reads 0.
REQ-032 ecall, csreg_en=1, csr_rd=2, csr_wd=0x80000010 -> mepc=0x80000010 and mcause=11; also csr_rd=3, csr_wd=7 with ecall -> mcause=11.
REQ-033 ifu_ready=0 for 4 cycles in SEND -> valid and dnpc stable for 4 cycles; a new wbu_receive_valid is not accepted; IDLE on the first ifu_ready=1.
REQ-034 ebreak, reg_en=1, rd=10, wd=0 -> rf[10]=0, halt=1, wbu_send_valid never asserts, and later valids are ignored until rst=0.
REQ-035 rst pulsed low asynchronously mid-SEND -> outputs reset immediately; instret preset to 0xFFFFFFFF then one commit -> 0.
